// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D-cache memory arbiter: FSM state and access owner.
package mem_arb_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef enum logic       {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  // Wide enough for any TIMEOUT up to 65535.
  localparam int CNT_W = 16;
endpackage

// File: rtl/arb_pick.sv
// Combinational winner select; ARB_RR_EN selects round-robin ties, else D-cache priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   ic_req_i,
  input  logic   dc_req_i,
  input  owner_e last_i,
  output owner_e winner_o
);
`ifdef ARB_RR_EN
  always_comb begin
    winner_o = dc_req_i ? OWN_D : OWN_I;
    // On a tie, whoever was not served last goes next.
    if (ic_req_i && dc_req_i) winner_o = (last_i == OWN_D) ? OWN_I : OWN_D;
  end
`else
  logic unused_arb;
  assign unused_arb = ic_req_i ^ last_i;
  always_comb winner_o = dc_req_i ? OWN_D : OWN_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between I-cache (read) and D-cache (read/write).
// All outputs registered; optional round-robin tie-break via ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, winner;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ic_gnt_q, ic_gnt_d, dc_gnt_q, dc_gnt_d;
  logic              ic_rvalid_q, ic_rvalid_d, dc_rvalid_q, dc_rvalid_d;
  logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d, err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done;
  logic [DATA_W-1:0] done_data;

  arb_pick u_pick (
    .ic_req_i (ic_req),
    .dc_req_i (dc_req),
    .last_i   (owner_q),
    .winner_o (winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ic_gnt_d    = 1'b0;
    dc_gnt_d    = 1'b0;
    ic_rvalid_d = 1'b0;
    dc_rvalid_d = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    done        = 1'b0;
    done_data   = '0;
    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          state_d  = BUSY;
          owner_d  = winner;
          cnt_d    = '0;
          mem_en_d = 1'b1;
          if (winner == OWN_D) begin
            dc_gnt_d    = 1'b1;
            mem_we_d    = dc_we;
            mem_addr_d  = dc_addr;
            mem_wdata_d = dc_wdata;
          end else begin
            ic_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = ic_addr;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY: begin
        // mem_ready wins over a watchdog expiry on the same edge.
        if (mem_ready) begin
          done      = 1'b1;
          done_data = mem_rdata;
        end else if (cnt_q == TMO) begin
          done  = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      if (owner_q == OWN_D) begin
        dc_rvalid_d = 1'b1;
        dc_rdata_d  = done_data;
      end else begin
        ic_rvalid_d = 1'b1;
        ic_rdata_d  = done_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      cnt_q       <= '0;
      ic_gnt_q    <= 1'b0;
      dc_gnt_q    <= 1'b0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ic_gnt_q    <= ic_gnt_d;
      dc_gnt_q    <= dc_gnt_d;
      ic_rvalid_q <= ic_rvalid_d;
      dc_rvalid_q <= dc_rvalid_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign ic_gnt    = ic_gnt_q;
  assign dc_gnt    = dc_gnt_q;
  assign ic_rvalid = ic_rvalid_q;
  assign dc_rvalid = dc_rvalid_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width of all data ports.
REQ-003 Parameter TIMEOUT, default 255, maximum BUSY cycles before watchdog abort, range 1..65535.
REQ-004 Clock and reset: clk input 1, single clock; rst input 1, reset, asynchronous, active-high.
REQ-005 I-cache request: ic_req input 1; ic_addr input ADDR_W; ic_gnt output 1; ic_rvalid output 1; ic_rdata output DATA_W.
REQ-006 D-cache request: dc_req input 1; dc_we input 1; dc_addr input ADDR_W; dc_wdata input DATA_W; dc_gnt output 1; dc_rvalid output 1; dc_rdata output DATA_W.
REQ-007 Memory port: mem_en output 1; mem_we output 1; mem_addr output ADDR_W; mem_wdata output DATA_W; mem_rdata input DATA_W; mem_ready input 1.
REQ-008 Status: err output 1, sticky watchdog flag.

Function
REQ-009 The block SHALL share one single-port backing memory between the I-cache (read-only) and the D-cache (read/write refill and writeback); all outputs SHALL be registered.
REQ-010 FSM states SHALL be IDLE and BUSY; an owner register SHALL record I or D.
REQ-011 In IDLE, at an edge where any req is high, the block SHALL register: the winner's gnt=1, mem_en=1, and mem_addr/mem_we/mem_wdata from the winner (mem_we=0 for I); state->BUSY.
REQ-012 gnt and mem_en SHALL be single-cycle pulses; in BUSY, mem_en=0 and mem_addr/mem_we/mem_wdata SHALL hold.
REQ-013 In BUSY, at an edge where mem_ready=1, the block SHALL register owner's rvalid=1 and rdata=mem_rdata (also for writes, as completion ack), and set state->IDLE.
REQ-014 Latency: gnt at cycle T+1 after req sampled at T; rvalid one cycle after mem_ready is sampled; the next grant SHALL be issued no earlier than the cycle after rvalid.
REQ-015 Requesters SHALL hold req, addr, we, wdata stable until gnt; req still high in the rvalid cycle SHALL be treated as a new request.
REQ-016 Both req high in IDLE: arbitration per REQ-022/023; the loser SHALL see no gnt and remain pending.
REQ-017 mem_ready in IDLE SHALL be ignored (no rvalid, no state change).
REQ-018 A TIMEOUT-cycle BUSY counter SHALL clear on grant; if TIMEOUT cycles elapse in BUSY without mem_ready, the block SHALL pulse owner's rvalid with rdata=0, set err=1, and return to IDLE.
REQ-019 The err output SHALL remain 1 until reset.

Reset
REQ-020 Asserting rst SHALL immediately force state=IDLE, owner=I, and all gnt, rvalid, mem_en, mem_we, and err outputs to 0; all addr/data outputs SHALL be forced to 0; the counter SHALL be 0.
REQ-021 Reset during BUSY SHALL abandon the access; no rvalid SHALL be issued for it, and a later stale mem_ready SHALL be ignored per REQ-017.

Configuration
REQ-022 With ARB_RR_EN defined, simultaneous requests SHALL be resolved round-robin: the requester not served last wins; the last-served requester resets to I, so D wins the first tie.
REQ-023 Without ARB_RR_EN, D-cache SHALL have fixed priority over I-cache.

Structure
REQ-024 Shared package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY) and the owner type (OWN_I, OWN_D).
REQ-025 The winner selection SHALL be one combinational sub-module, arb_pick (inputs ic_req, dc_req, last owner; output winner), containing the ARB_RR_EN selection.

Verification
REQ-026 I read: ic_req=1, ic_addr=0x0000_0040, mem_ready 3 cycles after mem_en with rdata=0x0010_0093 -> ic_gnt pulse at cycle 1, mem_en pulse with mem_addr=0x40, ic_rvalid with ic_rdata=0x0010_0093 one cycle after mem_ready.
REQ-027 D write: dc_we=1, dc_addr=0x9000, dc_wdata=0xDEAD_BEEF -> mem_we=1, mem_wdata=0xDEADBEEF, dc_rvalid ack after mem_ready, ic_rvalid stays 0.
REQ-028 Tie: ic_req and dc_req both held high for 4 transactions -> without ARB_RR_EN, D,D,D,D; with ARB_RR_EN, D,I,D,I.
REQ-029 Watchdog: TIMEOUT=8, mem_ready held 0 -> owner rvalid with rdata=0 on the 9th cycle after grant, err=1 and stays 1.
REQ-030 Reset mid-BUSY, then mem_ready=1 pulse -> all outputs 0 and no rvalid; a new ic_req is then granted normally.
REQ-031 Stray mem_ready in IDLE -> no rvalid, state remains IDLE.
